// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchroniser, 3-sample majority voting,
// runtime frame format, break detection and a valid/ready output register.
module uart_rx_cfg #(
  parameter int DATA_W     = 9,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  PAR_en,
  input  logic                  PAR_typ,
  input  logic [3:0]            data_len,
  input  logic                  stop_two,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  data_ready,
  output logic [DATA_W-1:0]     p_data,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error,
  output logic                  break_det,
  output logic                  overrun
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t state, state_next;

  logic rx_meta, rx_sync;

  // Frame configuration captured at start-bit detection
  logic                  par_en_q, par_typ_q, stop_two_q;
  logic [3:0]            len_q, len_clamped;
  logic [PRESCALE_W-1:0] pre_q;

  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] pos_a, pos_b, pos_c, pos_last;
  logic [3:0]            bit_cnt;
  logic                  stop_cnt;
  logic [DATA_W-1:0]     shift_reg;
  logic                  samp_a, samp_b;
  logic                  perr_q, serr_q, zero_q;

  logic in_frame, decide, wrap, vote, last_data, last_stop, par_expect;
  logic frame_done;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_sync <= rx_meta;
    end
  end

  always_comb begin
    if (data_len < 4'd5)
      len_clamped = 4'd5;
    else if (data_len > 4'(DATA_W))
      len_clamped = 4'(DATA_W);
    else
      len_clamped = data_len;
  end

  assign pos_b    = pre_q >> 1;
  assign pos_a    = pos_b - PRESCALE_W'(1);
  assign pos_c    = pos_b + PRESCALE_W'(1);
  assign pos_last = pre_q - PRESCALE_W'(1);

  assign in_frame   = state inside {START, DATA, PARITY, STOP};
  assign decide     = in_frame && (edge_cnt == pos_c);
  assign wrap       = in_frame && (edge_cnt == pos_last);
  assign vote       = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);
  assign last_data  = (bit_cnt == len_q - 4'd1);
  assign last_stop  = (stop_cnt == stop_two_q);
  assign par_expect = par_typ_q ? ~(^shift_reg) : (^shift_reg);

  always_ff @(posedge clk) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // NOTE: defaults first, so no path through the case leaves an output
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    case (state)
      IDLE:      if (!rx_sync) state_next = START;
      START: begin
        if (decide && vote)
          state_next = IDLE;
        else if (wrap)
          state_next = DATA;
      end
      DATA:      if (wrap && last_data) state_next = par_en_q ? PARITY : STOP;
      PARITY:    if (wrap) state_next = STOP;
      STOP: begin
        // Completing mid-bit leaves half a bit to re-arm for a back-to-back start
        if (decide && last_stop) begin
          frame_done = 1'b1;
          state_next = vote ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: if (rx_sync) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      shift_reg  <= '0;
      samp_a     <= 1'b1;
      samp_b     <= 1'b1;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
      zero_q     <= 1'b0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stop_two_q <= 1'b0;
      len_q      <= 4'd5;
      pre_q      <= '0;
    end else begin
      // The detection cycle itself is edge 0 of the start bit
      if (state == IDLE)
        edge_cnt <= rx_sync ? '0 : PRESCALE_W'(1);
      else if (state_next == IDLE || state_next == WAIT_HIGH || wrap)
        edge_cnt <= '0;
      else
        edge_cnt <= edge_cnt + PRESCALE_W'(1);

      if (state == IDLE && !rx_sync) begin
        par_en_q   <= PAR_en;
        par_typ_q  <= PAR_typ;
        stop_two_q <= stop_two;
        len_q      <= len_clamped;
        pre_q      <= prescale;
        bit_cnt    <= '0;
        stop_cnt   <= 1'b0;
        shift_reg  <= '0;
        perr_q     <= 1'b0;
        serr_q     <= 1'b0;
        zero_q     <= 1'b1;
      end

      if (in_frame && edge_cnt == pos_a) samp_a <= rx_sync;
      if (in_frame && edge_cnt == pos_b) samp_b <= rx_sync;

      if (decide) begin
        case (state)
          DATA: begin
            for (int i = 0; i < DATA_W; i++)
              if (bit_cnt == 4'(i)) shift_reg[i] <= vote;
            zero_q <= zero_q & ~vote;
          end
          PARITY: begin
            perr_q <= vote ^ par_expect;
            zero_q <= zero_q & ~vote;
          end
          STOP: begin
            serr_q <= serr_q | ~vote;
            zero_q <= zero_q & ~vote;
          end
          default: ;
        endcase
      end

      if (wrap) begin
        if (state == DATA && !last_data) bit_cnt <= bit_cnt + 4'd1;
        if (state == STOP) stop_cnt <= 1'b1;
      end
    end
  end

  // Output holding register; the last stop sample is folded in directly
  // because the accumulators update on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      p_data       <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      break_det    <= 1'b0;
      overrun      <= 1'b0;
    end else if (frame_done) begin
      if (!data_valid || data_ready) begin
        p_data       <= shift_reg;
        data_valid   <= 1'b1;
        parity_error <= perr_q;
        stop_error   <= serr_q | ~vote;
        break_det    <= zero_q & ~vote;
        overrun      <= 1'b0;
      end else begin
        overrun <= 1'b1;
      end
    end else if (data_valid && data_ready) begin
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver, second generation of the team's RX block. It adds:
- runtime-selectable data length (up to DATA_W bits)
- one or two stop bits
- 3-sample majority voting per bit, with start-bit glitch rejection
- break detection
- a valid/ready output handshake with overrun flagging

It sits between the pad-side serial line and the packet/CSR logic, clocked at prescale × baud.

## Interface
Parameters:
- DATA_W, 9, maximum data bits per frame (≥5)
- PRESCALE_W, 6, width of the prescale input

Ports:
- clk  in  1  oversampling clock
- rst  in  1  reset; one clock; reset is synchronous and active-low
- rx_in  in  1  serial line, idle high; asynchronous, 2-flop synchronised internally
- PAR_en  in  1  1 = parity bit present
- PAR_typ  in  1  0 = even, 1 = odd
- data_len  in  4  data bits per frame, legal 5..DATA_W
- stop_two  in  1  1 = two stop bits
- prescale  in  PRESCALE_W  clocks per bit, even, legal ≥6
- data_ready  in  1  consumer accepts word
- p_data  out  DATA_W  received word, LSB-first assembled, right-aligned, unused MSBs 0
- data_valid  out  1  word and flags valid
- parity_error  out  1  flag for held word
- stop_error  out  1  any stop bit sampled 0
- break_det  out  1  all-zero frame including stop
- overrun  out  1  a frame was dropped while holding this word

## Operation
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- edge_cnt runs 0..prescale−1 within each bit; bit_cnt counts data bits.
- Bit value = majority of synchronised samples taken at edge_cnt = prescale/2−1, prescale/2, prescale/2+1. It is decided at prescale/2+1.
- IDLE: synchronised rx_in = 0 → START with edge_cnt = 0. PAR_en, PAR_typ, data_len, stop_two and prescale are latched here; input changes mid-frame have no effect.
- START: majority 1 → glitch, return to IDLE, no output. Otherwise continue to DATA at edge_cnt wrap.
- DATA: shift in data_len bits LSB first. Then go to PARITY if the latched PAR_en = 1, else to STOP.
- PARITY:
  - expected bit = XOR(data) for even, ~XOR(data) for odd
  - mismatch → parity_error for this frame
- STOP: one or two stop bits; any sampled 0 → stop_error.
- Frame completes at the decision point of the last stop bit (not the end of the bit). Next state is IDLE if the last stop sample = 1, else WAIT_HIGH.
- WAIT_HIGH: stay until synchronised rx_in = 1, then IDLE. This prevents a held-low line from generating repeated frames.
- break_det = 1 when all data bits, the parity bit (if present) and all stop bits are 0. stop_error is also 1 for such a frame.
- Output register:
  - completed frame + flags load when data_valid = 0, or when data_valid & data_ready in the same cycle (simultaneous hand-off, no overrun)
  - if data_valid = 1 and data_ready = 0 at completion: new frame dropped, held word unchanged, overrun ← 1
  - handshake (data_valid & data_ready at a rising edge) clears data_valid and overrun unless a new frame loads in that cycle
- Reset (any time, including mid-frame): state IDLE, counters 0, all outputs 0, p_data = 0; the partial frame is discarded.

## Timing
- Synchroniser latency 2 cycles: a rx_in falling edge is seen in IDLE 2 cycles later. That cycle is edge_cnt = 0 of the start bit.
- Frame length in bits B = 1 + data_len + PAR_en + (1 + stop_two).
- data_valid rises 1 cycle after the cycle with edge_cnt = prescale/2+1 of the last stop bit. That is (B−1)·prescale + prescale/2 + 2 cycles after detection, plus 2 synchroniser cycles from the rx_in edge.
- Back-to-back frames with no idle gap are received correctly, because the receiver is back in IDLE before the stop bit ends.
- data_valid falls the cycle after the handshake edge.
- All flags are registered, aligned with p_data, and stable while data_valid = 1.

## Test plan
- prescale 8, data_len 8, odd parity, 1 stop, byte 0xA5 (parity bit 1), data_ready = 1 → p_data 0x0A5, data_valid for one cycle, all error flags 0.
- data_len 7, even parity, stop_two = 1, data 0x35, second stop bit driven 0 → p_data 0x035, parity_error 0, stop_error 1, next state WAIT_HIGH then IDLE.
- data_len 8, even parity, data 0x0F, parity bit driven 1 → parity_error 1, stop_error 0, p_data 0x00F.
- prescale 16, rx_in low for 3 cycles only → no data_valid, FSM back in IDLE within 12 cycles; a following valid frame 0x3C is received correctly.
- rx_in low for 14 bit times (data_len 8, PAR_en 1) → exactly one word: p_data 0x000, stop_error 1, break_det 1; no further data_valid until rx_in returns high and a new start bit arrives.
- Overrun:
  - data_ready = 0, frames 0x11 then 0x22 → p_data 0x011, overrun 1; raise data_ready → data_valid and overrun clear next cycle.
  - Repeat with data_ready pulsed in the exact completion cycle of 0x22 → 0x022 loaded, overrun 0.
